// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: reset sequencing, free-run and
// single-step clock gating, and stop on halt-PC match, cycle budget or abort.
module mips_run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32,
  parameter int PC_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_mode_i,
  input  logic             step_i,
  input  logic             abort_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic [PC_W-1:0]  halt_pc_i,
  input  logic [CNT_W-1:0] max_cycles_i,
  output logic             cpu_rst_o,
  output logic             cpu_clk_en_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             busy_o
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RSTSEQ, S_RUN, S_STEP, S_HALTED} state_e;

  state_e           state_q, state_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             clk_en_q, clk_en_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             mode_q, mode_d;
  logic             step_q;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             halt_hit, budget_hit, step_rise;

  // Counter saturates rather than wrapping on unlimited runs.
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign halt_hit   = (pc_i == halt_pc_i);
  assign budget_hit = (max_cycles_i != '0) && ((cnt_q + CNT_W'(1)) == max_cycles_i);
  assign step_rise  = step_i & ~step_q;

  always_comb begin
    state_d   = state_q;
    cpu_rst_d = cpu_rst_q;
    clk_en_d  = clk_en_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    mode_d    = mode_q;
    rcnt_d    = rcnt_q;
    cnt_d     = cnt_q;
    if (abort_i) begin
      state_d   = S_IDLE;
      cpu_rst_d = 1'b1;
      clk_en_d  = 1'b0;
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (start_i) begin
            state_d   = S_RSTSEQ;
            cpu_rst_d = 1'b1;
            clk_en_d  = 1'b0;
            cnt_d     = '0;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            mode_d    = step_mode_i;
            rcnt_d    = RW'(RST_CYCLES - 1);
          end
        end
        S_RSTSEQ: begin
          if (rcnt_q == '0) begin
            state_d   = mode_q ? S_STEP : S_RUN;
            cpu_rst_d = 1'b0;
            clk_en_d  = ~mode_q;
          end else begin
            rcnt_d = rcnt_q - RW'(1);
          end
        end
        S_RUN, S_STEP: begin
          if (clk_en_q) begin
            // Enabled edge: the instruction at pc_i retires and is counted.
            cnt_d    = cnt_inc;
            clk_en_d = (state_q == S_RUN);
            if (halt_hit) begin
              state_d  = S_HALTED;
              done_d   = 1'b1;
              clk_en_d = 1'b0;
            end else if (budget_hit) begin
              state_d   = S_HALTED;
              timeout_d = 1'b1;
              cnt_d     = max_cycles_i;
              clk_en_d  = 1'b0;
            end
          end else if (state_q == S_STEP && step_rise) begin
            clk_en_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_RSTSEQ) || (state_d == S_RUN) || (state_d == S_STEP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cpu_rst_q <= 1'b1;
      clk_en_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      mode_q    <= 1'b0;
      step_q    <= 1'b0;
      rcnt_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= cpu_rst_d;
      clk_en_q  <= clk_en_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      mode_q    <= mode_d;
      step_q    <= step_i;
      rcnt_q    <= rcnt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cpu_rst_o     = cpu_rst_q;
  assign cpu_clk_en_o  = clk_en_q;
  assign cycle_count_o = cnt_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: a behavioural core advances pc on enabled
// edges; each run's end state is predicted from halt_pc/max_cycles arithmetic.
module tb_mips_run_ctrl;

  localparam logic [31:0] BASE    = 32'h0000_3000;
  localparam logic [31:0] UNREACH = 32'h0004_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, step_mode = 1'b0, step = 1'b0, abort = 1'b0;
  logic [31:0] pc = BASE, halt_pc = 32'h0, max_cycles = 32'h0;
  logic        cpu_rst, cpu_clk_en, done, timeout, busy;
  logic [31:0] cycle_count;

  typedef struct {
    logic [31:0] cnt;
    logic        done;
    logic        tmo;
    logic        rst;
    logic        chk_en;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   en_cnt = 0;
  logic busy_prev = 1'b0;

  mips_run_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .step_mode_i(step_mode),
    .step_i(step), .abort_i(abort), .pc_i(pc), .halt_pc_i(halt_pc),
    .max_cycles_i(max_cycles), .cpu_rst_o(cpu_rst), .cpu_clk_en_o(cpu_clk_en),
    .cycle_count_o(cycle_count), .done_o(done), .timeout_o(timeout), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Behavioural core: fetch address steps by one word per enabled edge.
  always @(posedge clk) begin
    if (cpu_rst) pc <= BASE;
    else if (cpu_clk_en) pc <= pc + 32'd4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Enabled edge k (1-based) sees pc = BASE + 4(k-1); halt wins a tie with the budget.
  function automatic exp_t predict(input logic [31:0] hpc, input logic [31:0] mc);
    exp_t        e;
    longint      k;
    if (hpc >= BASE && hpc[1:0] == 2'b00) k = longint'((hpc - BASE) / 4) + 1;
    else k = 64'h7fff_ffff_ffff;
    e.rst = 1'b0; e.chk_en = 1'b1;
    if (mc != 0 && longint'(mc) < k) begin
      e.cnt = mc; e.done = 1'b0; e.tmo = 1'b1;
    end else begin
      e.cnt = 32'(k); e.done = 1'b1; e.tmo = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t stopped(input logic [31:0] cnt, input logic en_ok);
    exp_t e;
    e.cnt = cnt; e.done = 1'b0; e.tmo = 1'b0; e.rst = 1'b1; e.chk_en = en_ok;
    return e;
  endfunction

  // Monitor: every end of a busy period is scored against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (busy && !busy_prev) en_cnt = 0;
    if (busy && cpu_clk_en) en_cnt++;
    if (!busy && busy_prev) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL end_unexpected: run ended with no prediction at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("end_count", cycle_count, e.cnt);
        chk("end_done", 32'(done), 32'(e.done));
        chk("end_timeout", 32'(timeout), 32'(e.tmo));
        chk("end_cpu_rst", 32'(cpu_rst), 32'(e.rst));
        chk("end_clk_en", 32'(cpu_clk_en), 32'd0);
        if (e.chk_en) chk("end_en_pulses", 32'(en_cnt), e.cnt);
      end
    end
    busy_prev = busy;
  end

  task automatic start_run(input logic m, input logic [31:0] hpc, input logic [31:0] mc,
                           input exp_t e);
    halt_pc = hpc; max_cycles = mc; step_mode = m;
    q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; step_mode = 1'b0;
  endtask

  task automatic run_to_end(input logic stepping, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      if (stepping) step = ($urandom_range(0, 2) == 0);
      n++;
    end
    step = 1'b0;
    if (busy) begin
      $display("FAIL run_bound: still busy after %0d cycles", budget);
      $fatal(1, "run did not end");
    end
  endtask

  task automatic wait_cnt(input logic [31:0] v);
    int n;
    n = 0;
    while (cycle_count != v && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cycle_count != v) begin
      $display("FAIL wait_cnt: cycle_count %0d never reached %0d", cycle_count, v);
      $fatal(1, "cycle count wait expired");
    end
  endtask

  initial begin
    logic        m;
    int          k;
    logic [31:0] hpc, mc;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_clk_en", 32'(cpu_clk_en), 32'd0);
    chk("rst_count", cycle_count, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Reset sequence timing, then halt at 0x3010 (fifth enabled edge).
    start_run(1'b0, 32'h0000_3010, 32'd0, predict(32'h0000_3010, 32'd0));
    chk("seq1_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("seq1_busy", 32'(busy), 32'd1);
    chk("seq1_clk_en", 32'(cpu_clk_en), 32'd0);
    @(negedge clk);
    chk("seq2_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("seq2_clk_en", 32'(cpu_clk_en), 32'd0);
    @(negedge clk);
    chk("seq3_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("seq3_clk_en", 32'(cpu_clk_en), 32'd1);
    run_to_end(1'b0, 100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_count", cycle_count, 32'd5);
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_clk_en", 32'(cpu_clk_en), 32'd0);
    end

    // Budget exhaustion, then a halt landing on the last budgeted edge.
    start_run(1'b0, UNREACH, 32'd7, predict(UNREACH, 32'd7));
    run_to_end(1'b0, 100);
    start_run(1'b0, BASE + 32'd24, 32'd7, predict(BASE + 32'd24, 32'd7));
    run_to_end(1'b0, 100);

    // Single-step: a held step counts once, each separate pulse once more.
    start_run(1'b1, UNREACH, 32'd0, stopped(32'd4, 1'b1));
    repeat (3) @(negedge clk);
    step = 1'b1;
    repeat (5) @(negedge clk);
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (3) @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("step_count", cycle_count, 32'd4);
    chk("step_clk_en", 32'(cpu_clk_en), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // Abort on run cycle 3, restart, and a start pulse ignored while running.
    start_run(1'b0, UNREACH, 32'd0, stopped(32'd3, 1'b0));
    wait_cnt(32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start_run(1'b0, BASE + 32'd20, 32'd0, predict(BASE + 32'd20, 32'd0));
    chk("restart_clear", cycle_count, 32'd0);
    chk("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    wait_cnt(32'd2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to_end(1'b0, 100);

    // Synchronous reset in the middle of a free run.
    start_run(1'b0, UNREACH, 32'd0, stopped(32'd0, 1'b0));
    wait_cnt(32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized runs in both modes.
    for (int r = 0; r < 14; r++) begin
      m   = 1'($urandom_range(0, 1));
      k   = $urandom_range(1, 15);
      hpc = ($urandom_range(0, 3) == 0) ? UNREACH : BASE + 32'(4 * (k - 1));
      mc  = $urandom_range(0, 15);
      if (hpc == UNREACH && mc == 0) mc = 32'd9;
      start_run(m, hpc, mc, predict(hpc, mc));
      run_to_end(m, 600);
      repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Parametrised, synthesizable run controller for the single-cycle MIPS core.
- Replaces hand-written clock/reset sequencing with a configurable reset sequencer, a free-run mode and a single-step mode.
- Stop conditions: halt-PC match, cycle budget (timeout) or abort.
- Sits between the board/bench and the core. Drives the core's reset and clock enable, and watches the core's PC output.

Parameters:
- RST_CYCLES, 2: number of clock cycles cpu_rst is held after a start (≥1).
- CNT_W, 32: width of cycle_count and max_cycles.
- PC_W, 32: width of pc and halt_pc.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin a reset-and-run sequence; sampled in IDLE or HALTED.
- step_mode, input, 1: sampled with start; 1 selects single-step, 0 selects free-run.
- step, input, 1: step request in single-step mode; rising-edge detected.
- abort, input, 1: return to IDLE from any state.
- pc, input, PC_W: current core PC.
- halt_pc, input, PC_W: stop address.
- max_cycles, input, CNT_W: cycle budget; 0 means unlimited.
- cpu_rst, output, 1: reset to the core.
- cpu_clk_en, output, 1: clock enable to the core; the core advances only on edges where this is 1.
- cycle_count, output, CNT_W: number of enabled edges since the last start.
- done, output, 1: run ended on a halt-PC match.
- timeout, output, 1: run ended on budget exhaustion.
- busy, output, 1: high in RSTSEQ, RUN and STEP.

Behaviour:
- All outputs are registered. On rst: state=IDLE, cpu_rst=1, cpu_clk_en=0, cycle_count=0, done=0, timeout=0, busy=0, step-edge register=0.
- rst has priority over abort; abort has priority over all other inputs.

States:
- IDLE: cpu_rst=1, cpu_clk_en=0.
  - start=1 → RSTSEQ; clear cycle_count, done and timeout; latch step_mode into a mode register; load the reset counter with RST_CYCLES-1.
- RSTSEQ: cpu_rst=1.
  - Counter decrements each cycle.
  - At counter==0 → RUN (mode=0) or STEP (mode=1); cpu_rst=0 from that edge.
  - cpu_rst is therefore high for exactly RST_CYCLES cycles after the start edge.
  - If mode=0, cpu_clk_en=1 from the same edge that cpu_rst falls.
- RUN: cpu_clk_en=1. On every edge with cpu_clk_en=1, cycle_count+1.
  - If pc==halt_pc at an enabled edge: that instruction executes and is counted. Go to HALTED; done=1; cpu_clk_en=0 from that edge.
  - Else if max_cycles≠0 and cycle_count+1==max_cycles: go to HALTED; timeout=1; cycle_count=max_cycles; cpu_clk_en=0.
  - Both conditions on the same edge: done=1, timeout=0 (halt wins).
- STEP: cpu_clk_en=0 except for a one-cycle pulse.
  - The pulse is asserted on the edge after step is detected 0→1 (step_q==0, step==1).
  - The enabled edge is counted, and the halt and timeout checks apply exactly as in RUN.
  - Holding step high gives one step only. A new step edge while a pulse is in flight is ignored.
- HALTED: cpu_rst=0, cpu_clk_en=0; cycle_count, done and timeout hold.
  - start=1 → RSTSEQ with the same clears as from IDLE.
- start while busy is ignored.
- abort in any state → IDLE next edge: cpu_rst=1, cpu_clk_en=0, done=0, timeout=0. cycle_count holds its value for inspection.
- cycle_count saturates at all-ones when max_cycles=0; it does not wrap.
- rst asserted mid-run returns to IDLE with full reset values on the next edge.
- halt_pc and max_cycles are used live (not latched); the bench holds them stable while busy.

Test Plan:
- Reset sequence: rst 1 for 2 cycles, then start pulse, step_mode=0, RST_CYCLES=2 → cpu_rst high for exactly 2 cycles after the start edge; cpu_clk_en rises on the same edge cpu_rst falls; busy=1.
- Halt: pc driven 0x00003000 + 4·n per enabled edge, halt_pc=0x00003010, max_cycles=0 → done=1, timeout=0, cycle_count=5, cpu_clk_en=0; values hold for 10 further cycles.
- Timeout and tie: halt_pc unreachable, max_cycles=7 → timeout=1, cycle_count=7, exactly 7 enable cycles. Rerun with halt reached on cycle 7 → done=1, timeout=0.
- Single-step: step_mode=1; step held high for 5 cycles, then 3 separate 1-cycle pulses → exactly 4 one-cycle cpu_clk_en pulses; cycle_count=4.
- Abort and restart: abort asserted on run cycle 3 → IDLE, cpu_rst=1, cycle_count=3. A new start clears cycle_count to 0 and repeats the reset sequence. A start pulse during RUN has no effect.
- Reset mid-run: rst asserted on cycle 4 of RUN → all outputs at reset values on the next edge, including cycle_count=0.
